// File: rtl/cskips_60bit_seq.sv
// Block-serial borrow-skip subtractor: diff = minuend - subtrahend - bin, one BLOCK-bit slice per cycle.
// Optional build macro CSKIPS_EARLY_DONE_EN finishes early once the remaining upper operand bits are all zero.
module cskips_60bit_seq #(
  parameter int WIDTH = 60,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_minuend,
  input  logic [WIDTH-1:0] i_subtrahend,
  input  logic             i_bin,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_bout
);

  // state | meaning
  // IDLE  | waiting for operands, o_ready=1
  // RUN   | subtracting block k, one block per cycle
  // DONE  | result presented, o_valid=1 until i_ready
  localparam int NBLK = WIDTH / BLOCK;
  localparam int KW   = (NBLK > 1) ? $clog2(NBLK) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             borrow_q;
  logic [KW-1:0]    k_q;

  logic [BLOCK-1:0] blk_a;
  logic [BLOCK-1:0] blk_b;
  logic [BLOCK:0]   rip;
  logic             blk_p;
  logic             borrow_nxt;
  logic             last_blk;

  always_comb begin
    blk_a      = a_q[k_q*BLOCK +: BLOCK];
    blk_b      = b_q[k_q*BLOCK +: BLOCK];
    rip        = {1'b0, blk_a} - {1'b0, blk_b} - {{BLOCK{1'b0}}, borrow_q};
    blk_p      = &(blk_a ~^ blk_b);
    // A block whose bit pairs all match passes the incoming borrow straight through.
    borrow_nxt = blk_p ? borrow_q : rip[BLOCK];
    last_blk   = (k_q == KW'(NBLK - 1));
  end

`ifdef CSKIPS_EARLY_DONE_EN
  logic [WIDTH-1:0] hi_mask;
  logic             early;

  always_comb begin
    hi_mask = {WIDTH{1'b1}} << (k_q * BLOCK);
    early   = (k_q != '0) && (((a_q | b_q) & hi_mask) == '0);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      o_ready  <= 1'b1;
      o_valid  <= 1'b0;
      o_diff   <= '0;
      o_bout   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      k_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            a_q      <= i_minuend;
            b_q      <= i_subtrahend;
            borrow_q <= i_bin;
            k_q      <= '0;
            o_diff   <= '0;
            o_ready  <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          o_diff[k_q*BLOCK +: BLOCK] <= rip[BLOCK-1:0];
          borrow_q <= borrow_nxt;
          k_q      <= k_q + 1'b1;
          if (last_blk) begin
            o_bout  <= borrow_nxt;
            o_valid <= 1'b1;
            state   <= DONE;
          end
`ifdef CSKIPS_EARLY_DONE_EN
          // Zero upper operands leave only the borrow to propagate: fill with it and stop.
          if (early) begin
            o_diff  <= o_diff | (borrow_q ? hi_mask : '0);
            o_bout  <= borrow_q;
            o_valid <= 1'b1;
            state   <= DONE;
          end
`endif
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          o_ready <= 1'b1;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
